ioctl_save_uploader: RTL

- Serves HPS upload requests (FPGA→HPS, the opposite direction to BIOS/ROM/YM downloads) for the save/NVRAM region of the Aznable system.
- Reads bytes from a fixed-latency synchronous RAM port and presents them on ioctl_din, holding ioctl_wait until each byte is valid.
- Tracks core writes to save RAM; after a quiet period it pulses an upload request so hps_io saves the data automatically.

---
 rtl/ioctl_save_uploader.sv | 115 +++++++++++
 1 files changed

// File: rtl/ioctl_save_uploader.sv
// Save/NVRAM upload responder for hps_io: streams save RAM bytes on ioctl_din and
// requests an automatic upload once the core has stopped writing for IDLE_CYCLES.
module ioctl_save_uploader #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned SAVE_SIZE    = 4096,
    parameter logic [7:0]  UPLOAD_INDEX = 8'd5,
    parameter int unsigned MEM_LAT      = 1,
    parameter int unsigned IDLE_CYCLES  = 24000000,
    parameter int unsigned CNT_W        = 25
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ioctl_upload_req,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data,
    input  logic              cpu_save_wr
);

    localparam int unsigned LAT_W      = 3;
    localparam logic [24:0] SAVE_LIMIT = 25'(SAVE_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE
    } state_t;

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic             dirty;
    logic [CNT_W-1:0] idle_cnt;
    logic             sel_c;

    assign sel_c = ioctl_upload && (ioctl_index == UPLOAD_INDEX);

    // Read path: mem_data is sampled on the MEM_LAT-th edge after the mem_rd edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_IDLE;
            lat_cnt    <= '0;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            busy       <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            busy   <= sel_c;
            case (state)
                S_IDLE: begin
                    if (ioctl_rd && sel_c) begin
                        if (ioctl_addr < SAVE_LIMIT) begin
                            mem_addr   <= ioctl_addr[ADDR_W-1:0];
                            mem_rd     <= 1'b1;
                            ioctl_wait <= 1'b1;
                            lat_cnt    <= LAT_W'(MEM_LAT);
                            state      <= S_FETCH;
                        end else begin
                            ioctl_din <= 8'hFF;
                        end
                    end
                end
                S_FETCH: begin
                    if (lat_cnt == LAT_W'(1)) begin
                        ioctl_din <= mem_data;
                        state     <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_DONE: begin
                    ioctl_wait <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Dirty tracking: a core write restarts the quiet period; the counter parks at the
    // threshold while an upload is running so the request goes out as soon as it ends.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dirty            <= 1'b0;
            idle_cnt         <= '0;
            ioctl_upload_req <= 1'b0;
        end else begin
            ioctl_upload_req <= 1'b0;
            if (cpu_save_wr) begin
                dirty    <= 1'b1;
                idle_cnt <= '0;
            end else if (dirty) begin
                if (idle_cnt >= CNT_LAST) begin
                    if (!ioctl_upload && !ioctl_upload_req) begin
                        ioctl_upload_req <= 1'b1;
                        dirty            <= 1'b0;
                        idle_cnt         <= '0;
                    end
                end else begin
                    idle_cnt <= idle_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
